// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets, default
// line count and the CLAIM valid-bit position.
package irq_pkg;

   localparam int IRQ_N_DEFAULT   = 5;
   localparam int CLAIM_VALID_BIT = 31;

   localparam logic [4:0] IRQ_PENDING = 5'h00;
   localparam logic [4:0] IRQ_MASK    = 5'h04;
   localparam logic [4:0] IRQ_MODE    = 5'h08;
   localparam logic [4:0] IRQ_CLAIM   = 5'h0C;
   localparam logic [4:0] IRQ_POL     = 5'h10;

   // Registers are word-aligned; byte-lane bits of the offset are ignored.
   function automatic logic [2:0] word_idx(input logic [4:0] off);
      return off[4:2];
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Register-window bus between the data-bus master and the interrupt controller.
// Single-cycle accesses, no back-pressure: an access is taken when i_bus_en is high.
interface irq_controller_if;

   logic        i_bus_en;
   logic        i_bus_we;
   logic [4:0]  i_bus_addr;
   logic [31:0] i_bus_wdata;
   logic [31:0] o_bus_rdata;

   modport master (
      output i_bus_en, i_bus_we, i_bus_addr, i_bus_wdata,
      input  o_bus_rdata
   );

   modport slave (
      input  i_bus_en, i_bus_we, i_bus_addr, i_bus_wdata,
      output o_bus_rdata
   );

endinterface

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for one asynchronous interrupt source.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stage_q;
   logic [SYNC_STAGES-1:0] stage_d;

   always_comb begin
      stage_d = {stage_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stage_q <= '0;
      else        stage_q <= stage_d;
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronises sources, applies polarity/mode/mask and
// exposes PENDING/MASK/MODE/CLAIM/POL through a one-cycle register window.
module irq_controller
   import irq_pkg::*;
#(
   parameter int N_IRQ       = IRQ_N_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] i_irq_src,
   irq_controller_if.slave  bus,
   input  logic             i_ack,
   input  logic [2:0]       i_ack_id,
   output logic [N_IRQ-1:0] o_interruption
);

   logic [N_IRQ-1:0] sync_out;
   logic [N_IRQ-1:0] act;
   logic [N_IRQ-1:0] pending_q, pending_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] mode_q, mode_d;
   logic [N_IRQ-1:0] pol_q, pol_d;
   logic [N_IRQ-1:0] act_d_q, act_d_d;
   logic [N_IRQ-1:0] irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [N_IRQ-1:0] set_v, clr_v, claim_vec;
   logic [2:0]       claim_id;
   logic             wr, rd;
   logic [2:0]       sel;
   logic             unused_bits;

   assign unused_bits = ^{bus.i_bus_wdata[31:N_IRQ], bus.i_bus_addr[1:0]};

   for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
      irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (i_irq_src[g]),
         .q     (sync_out[g])
      );
   end

   always_comb begin
      wr  = bus.i_bus_en & bus.i_bus_we;
      rd  = bus.i_bus_en & ~bus.i_bus_we;
      sel = bus.i_bus_addr[4:2];

      mask_d = mask_q;
      mode_d = mode_q;
      pol_d  = pol_q;
      if (wr && sel == word_idx(IRQ_MASK)) mask_d = bus.i_bus_wdata[N_IRQ-1:0];
      if (wr && sel == word_idx(IRQ_MODE)) mode_d = bus.i_bus_wdata[N_IRQ-1:0];
      if (wr && sel == word_idx(IRQ_POL))  pol_d  = bus.i_bus_wdata[N_IRQ-1:0];

      // New polarity applies in the write cycle, so a flip can raise an edge.
      act     = sync_out ^ pol_d;
      act_d_d = act;

      set_v     = '0;
      clr_v     = '0;
      pending_d = pending_q;
      for (int i = 0; i < N_IRQ; i++) begin
         if (mode_q[i]) begin
            set_v[i] = act[i] & ~act_d_q[i];
            clr_v[i] = (wr && sel == word_idx(IRQ_PENDING) && bus.i_bus_wdata[i]) ||
                       (i_ack && int'(i_ack_id) == i);
            pending_d[i] = set_v[i] | (pending_q[i] & ~clr_v[i]);
         end else begin
            pending_d[i] = act[i];
         end
         if (mode_d[i] != mode_q[i]) pending_d[i] = 1'b0;
      end

      irq_d = pending_d & mask_d;

      claim_vec = pending_q & mask_q;
      claim_id  = 3'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (claim_vec[i]) claim_id = 3'(i);
      end

      // Reads see pre-update state and hold until the next read.
      rdata_d = rdata_q;
      if (rd) begin
         rdata_d = '0;
         case (sel)
            word_idx(IRQ_PENDING): rdata_d[N_IRQ-1:0] = pending_q;
            word_idx(IRQ_MASK):    rdata_d[N_IRQ-1:0] = mask_q;
            word_idx(IRQ_MODE):    rdata_d[N_IRQ-1:0] = mode_q;
            word_idx(IRQ_CLAIM): begin
               rdata_d[CLAIM_VALID_BIT] = |claim_vec;
               rdata_d[2:0]             = claim_id;
            end
            word_idx(IRQ_POL):     rdata_d[N_IRQ-1:0] = pol_q;
            default:               rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         mask_q    <= '0;
         mode_q    <= '0;
         pol_q     <= '0;
         act_d_q   <= '0;
         irq_q     <= '0;
         rdata_q   <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         pol_q     <= pol_d;
         act_d_q   <= act_d_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
      end
   end

   assign o_interruption  = irq_q;
   assign bus.o_bus_rdata = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: inputs change and outputs are sampled on
// the falling clock edge; each bus access occupies one full clock cycle.
module tb_irq_controller;
   import irq_pkg::*;

   logic       clk;
   logic       reset;
   logic [4:0] i_irq_src;
   logic       i_ack;
   logic [2:0] i_ack_id;
   logic [4:0] o_interruption;
   logic [31:0] rdv;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   irq_controller_if bif ();

   irq_controller #(.N_IRQ(5), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_irq_src      (i_irq_src),
      .bus            (bif.slave),
      .i_ack          (i_ack),
      .i_ack_id       (i_ack_id),
      .o_interruption (o_interruption)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      bif.i_bus_en    = 1'b1;
      bif.i_bus_we    = 1'b1;
      bif.i_bus_addr  = a;
      bif.i_bus_wdata = d;
      @(negedge clk);
      bif.i_bus_en    = 1'b0;
      bif.i_bus_we    = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      bif.i_bus_en   = 1'b1;
      bif.i_bus_we   = 1'b0;
      bif.i_bus_addr = a;
      @(negedge clk);
      bif.i_bus_en   = 1'b0;
      d = bif.o_bus_rdata;
   endtask

   task automatic ack(input logic [2:0] id);
      i_ack    = 1'b1;
      i_ack_id = id;
      @(negedge clk);
      i_ack    = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      reset           = 1'b0;
      i_irq_src       = 5'b10101;
      i_ack           = 1'b0;
      i_ack_id        = 3'd0;
      bif.i_bus_en    = 1'b0;
      bif.i_bus_we    = 1'b0;
      bif.i_bus_addr  = 5'h00;
      bif.i_bus_wdata = 32'h0;

      // Held in reset with sources active
      tick(3);
      chk("rst_irq",   32'(o_interruption), 32'h0);
      chk("rst_rdata", bif.o_bus_rdata,     32'h0);

      reset = 1'b1;
      tick(4);
      chk("mask0_irq", 32'(o_interruption), 32'h0);
      bus_rd(IRQ_PENDING, rdv); chk("level_pending_15", rdv, 32'h15);
      bus_rd(IRQ_CLAIM, rdv);   chk("claim_masked_off", rdv, 32'h0);

      // All lines edge mode, all enabled
      i_irq_src = 5'b00000;
      tick(4);
      bus_wr(IRQ_MODE, 32'h1F);
      bus_wr(IRQ_MASK, 32'h1F);
      chk("edge_idle", 32'(o_interruption), 32'h0);
      bus_rd(IRQ_MODE, rdv); chk("mode_rb", rdv, 32'h1F);

      // Single-cycle pulse on line 2
      i_irq_src = 5'b00100;
      tick(1);
      i_irq_src = 5'b00000;
      tick(1);
      chk("pulse_edge2", 32'(o_interruption), 32'h0);
      tick(1);
      chk("pulse_edge3", 32'(o_interruption), 32'h04);
      bus_rd(IRQ_CLAIM, rdv); chk("claim_line2", rdv, 32'h8000_0002);
      ack(3'd7);
      chk("ack_bad_id", 32'(o_interruption), 32'h04);
      ack(3'd2);
      chk("ack_clear", 32'(o_interruption), 32'h0);

      // W1C in the same cycle as a new rising edge on line 0
      i_irq_src = 5'b00001;
      tick(2);
      bus_wr(IRQ_PENDING, 32'h1);
      chk("w1c_vs_set", 32'(o_interruption), 32'h01);
      bus_wr(IRQ_PENDING, 32'h1);
      chk("w1c_clear", 32'(o_interruption), 32'h0);
      i_irq_src = 5'b00000;
      tick(3);

      // Line 4 level mode, active-low, source low
      bus_wr(IRQ_MODE, 32'h0F);
      bus_wr(IRQ_POL, 32'h10);
      chk("pol_level_irq", 32'(o_interruption), 32'h10);
      bus_rd(IRQ_PENDING, rdv); chk("pol_level_pend", rdv, 32'h10);
      bus_wr(IRQ_PENDING, 32'h10);
      bus_rd(IRQ_PENDING, rdv); chk("level_w1c_ignored", rdv, 32'h10);
      i_irq_src = 5'b10000;
      tick(2);
      chk("level_hold_e2", 32'(o_interruption), 32'h10);
      tick(1);
      chk("level_clear_e3", 32'(o_interruption), 32'h0);

      // Line 4 back to edge; polarity flip creates a rising edge
      bus_wr(IRQ_MODE, 32'h1F);
      chk("mode_change_clr", 32'(o_interruption), 32'h0);
      bus_wr(IRQ_POL, 32'h00);
      chk("pol_edge_set", 32'(o_interruption), 32'h10);
      i_irq_src = 5'b00000;
      tick(3);
      bus_wr(IRQ_PENDING, 32'h10);
      chk("w1c_line4", 32'(o_interruption), 32'h0);

      // Mask subset with lines 0,1,3 pending
      bus_wr(IRQ_MASK, 32'h0A);
      i_irq_src = 5'b01011;
      tick(1);
      i_irq_src = 5'b00000;
      tick(2);
      chk("mask_0a", 32'(o_interruption), 32'h0A);
      bus_rd(IRQ_CLAIM, rdv);   chk("claim_line1", rdv, 32'h8000_0001);
      bus_rd(5'h14, rdv);       chk("rd_0x14", rdv, 32'h0);
      bus_rd(5'h1C, rdv);       chk("rd_0x1c", rdv, 32'h0);
      bus_rd(IRQ_PENDING, rdv); chk("pend_0b", rdv, 32'h0B);
      bus_wr(IRQ_MASK, 32'h1F);
      chk("mask_wr_same_edge", 32'(o_interruption), 32'h0B);
      bus_wr(5'h14, 32'hFFFF_FFFF);
      bus_rd(IRQ_MASK, rdv);    chk("unmapped_wr_ignored", rdv, 32'h1F);

      // Reset asserted mid-pulse with everything pending
      i_irq_src = 5'b11111;
      tick(3);
      chk("all_pending", 32'(o_interruption), 32'h1F);
      bus_rd(IRQ_PENDING, rdv); chk("pend_1f", rdv, 32'h1F);
      bus_rd(IRQ_CLAIM, rdv);   chk("claim_line0", rdv, 32'h8000_0000);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_irq",   32'(o_interruption), 32'h0);
      chk("async_rst_rdata", bif.o_bus_rdata,     32'h0);
      @(negedge clk);
      i_irq_src = 5'b00000;
      reset = 1'b1;
      tick(4);
      chk("post_rst_irq", 32'(o_interruption), 32'h0);
      bus_rd(IRQ_MASK, rdv);    chk("post_rst_mask", rdv, 32'h0);
      bus_rd(IRQ_MODE, rdv);    chk("post_rst_mode", rdv, 32'h0);
      bus_rd(IRQ_PENDING, rdv); chk("post_rst_pend", rdv, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
